// File: rtl/cpu_pkg.sv
// cpu_pkg: shared opcodes, widths, reset default and fetch FSM encoding
package cpu_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] RESET_PC_DEF = 32'h0000_0000;
  localparam logic [5:0] OP_JUMP  = 6'b010010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LOAD  = 6'b100011;
  localparam logic [5:0] OP_STORE = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  typedef enum logic {IDLE, RUN} fetch_state_e;
endpackage

// File: rtl/if_next_pc.sv
// if_next_pc: sequential and unconditional-jump successor of a pc
module if_next_pc import cpu_pkg::*; #(
  parameter logic [5:0] JUMP_OP = cpu_pkg::OP_JUMP
) (
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] inst,
  output logic [XLEN-1:0] pc4,
  output logic [XLEN-1:0] next_pc,
  output logic            is_jump
);
  always_comb begin
    pc4 = pc + 32'd4;
    is_jump = inst[31:26] == JUMP_OP;
    next_pc = is_jump ? {pc4[31:28], inst[25:0], 2'b00} : pc4;
  end
endmodule

// File: rtl/if_fetch_stage.sv
// if_fetch_stage: pc owner driving the instruction ROM into a valid/ready IF/ID register
module if_fetch_stage import cpu_pkg::*; #(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEF,
  parameter logic [5:0] OP_JUMP = cpu_pkg::OP_JUMP
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_en,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_inst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic [31:0] out_pc,
  output logic [31:0] out_pc4,
  output logic [31:0] fetch_count
);
  fetch_state_e state_q, state_d;
  logic [31:0] pc_q, pc_d, out_inst_q, out_inst_d, out_pc_q, out_pc_d;
  logic [31:0] out_pc4_q, out_pc4_d, cnt_q, cnt_d, pc4, next_pc, pc_nxt;
  logic out_valid_q, out_valid_d, is_jump, fire;
  if_next_pc #(.JUMP_OP(OP_JUMP)) u_next_pc (
    .pc(pc_q),
    .inst(imem_inst),
    .pc4(pc4),
    .next_pc(next_pc),
    .is_jump(is_jump)
  );
  always_comb begin
    pc_nxt = is_jump ? next_pc : pc4;
    fire = state_q == RUN && fetch_en && !redirect_valid && (!out_valid_q || out_ready);
    state_d = fetch_en ? RUN : IDLE;
    pc_d = redirect_valid ? {redirect_pc[31:2], 2'b00} : fire ? pc_nxt : pc_q;
    // redirect flushes IF/ID even while downstream is stalling
    out_valid_d = !redirect_valid && (fire || (out_valid_q && !out_ready));
    out_inst_d = fire ? imem_inst : out_inst_q;
    out_pc_d = fire ? pc_q : out_pc_q;
    out_pc4_d = fire ? pc4 : out_pc4_q;
    cnt_d = cnt_q + {31'd0, fire};
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q <= RESET_PC;
      out_valid_q <= 1'b0;
      out_inst_q <= '0;
      out_pc_q <= '0;
      out_pc4_q <= '0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      out_valid_q <= out_valid_d;
      out_inst_q <= out_inst_d;
      out_pc_q <= out_pc_d;
      out_pc4_q <= out_pc4_d;
      cnt_q <= cnt_d;
    end
  end
  assign imem_addr = pc_q;
  assign out_valid = out_valid_q;
  assign out_inst = out_inst_q;
  assign out_pc = out_pc_q;
  assign out_pc4 = out_pc4_q;
  assign fetch_count = cnt_q;
endmodule

// File: tb/tb_if_fetch_stage.sv
// tb_if_fetch_stage: directed and random checks of the fetch stage against a behavioural model
module tb_if_fetch_stage;
  logic clk = 1'b0, rst_n, fetch_en, redirect_valid, out_valid, out_ready;
  logic [31:0] imem_addr, imem_inst, redirect_pc, out_inst, out_pc, out_pc4, fetch_count;
  logic [31:0] rom [64];
  logic [31:0] m_pc, m_inst, m_opc, m_cnt;
  logic m_run, m_valid;
  int n_tests = 0, n_fail = 0;
  always #5 clk = ~clk;
  assign imem_inst = rom[imem_addr[7:2]];
  if_fetch_stage dut (
    .clk(clk), .rst_n(rst_n), .fetch_en(fetch_en), .imem_addr(imem_addr),
    .imem_inst(imem_inst), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst),
    .out_pc(out_pc), .out_pc4(out_pc4), .fetch_count(fetch_count)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic model_step();
    logic [31:0] inst, p4, nxt;
    logic fire;
    if (!rst_n) begin
      m_pc = 0; m_run = 0; m_valid = 0; m_inst = 0; m_opc = 0; m_cnt = 0;
    end else begin
      inst = rom[m_pc[7:2]];
      p4 = m_pc + 4;
      nxt = (inst[31:26] == 6'b010010) ? {p4[31:28], inst[25:0], 2'b00} : p4;
      fire = m_run && fetch_en && !redirect_valid && (!m_valid || out_ready);
      if (redirect_valid) begin
        m_pc = redirect_pc & 32'hFFFF_FFFC;
        m_valid = 0;
      end else if (fire) begin
        m_inst = inst; m_opc = m_pc; m_valid = 1; m_cnt = m_cnt + 1; m_pc = nxt;
      end else if (out_ready) m_valid = 0;
      m_run = fetch_en;
    end
  endtask
  task automatic cyc(input logic r, fe, rdy, rv, input logic [31:0] rp);
    rst_n = r; fetch_en = fe; out_ready = rdy; redirect_valid = rv; redirect_pc = rp;
    @(posedge clk);
    model_step();
    #1;
    chk("m_valid", {31'd0, out_valid}, {31'd0, m_valid});
    chk("m_addr", imem_addr, m_pc);
    chk("m_count", fetch_count, m_cnt);
    if (m_valid) begin
      chk("m_inst", out_inst, m_inst);
      chk("m_pc", out_pc, m_opc);
      chk("m_pc4", out_pc4, m_opc + 32'd4);
    end
  endtask
  initial begin
    logic [31:0] w, c0;
    int k;
    for (int i = 0; i < 64; i++) begin
      w = $urandom;
      if (w[31:26] == 6'b010010) w[26] = 1'b1;
      rom[i] = w;
    end
    rom[16] = 32'h4800_0001;
    repeat (3) cyc(0, 1, 1, 0, 0);
    chk("rst_valid", {31'd0, out_valid}, 0);
    chk("rst_addr", imem_addr, 0);
    chk("rst_count", fetch_count, 0);
    chk("rst_outpc", out_pc, 0);
    cyc(1, 1, 1, 0, 0);
    chk("idle_to_run", {31'd0, out_valid}, 0);
    cyc(1, 1, 1, 0, 0);
    chk("first_valid", {31'd0, out_valid}, 1);
    chk("first_pc", out_pc, 0);
    for (int i = 1; i <= 16; i++) begin
      cyc(1, 1, 1, 0, 0);
      chk("seq_pc", out_pc, 32'(i * 4));
    end
    chk("seq_count", fetch_count, 17);
    cyc(1, 1, 1, 0, 0);
    chk("jump_pc", out_pc, 32'h4);
    chk("jump_count", fetch_count, 18);
    k = 0;
    while (out_pc != 32'hC && k < 40) begin cyc(1, 1, 1, 0, 0); k++; end
    chk("bp_reach", {31'd0, k < 40}, 1);
    c0 = fetch_count;
    for (int i = 0; i < 3; i++) begin
      cyc(1, 1, 0, 0, 0);
      chk("bp_hold_pc", out_pc, 32'hC);
      chk("bp_hold_addr", imem_addr, 32'h10);
      chk("bp_hold_cnt", fetch_count, c0);
    end
    cyc(1, 1, 1, 0, 0);
    chk("bp_release", out_pc, 32'h10);
    c0 = fetch_count;
    cyc(1, 1, 0, 1, 32'h22);
    chk("rd_flush", {31'd0, out_valid}, 0);
    chk("rd_addr", imem_addr, 32'h20);
    chk("rd_count", fetch_count, c0);
    cyc(1, 1, 1, 0, 0);
    chk("rd_target", out_pc, 32'h20);
    cyc(1, 1, 1, 1, 32'h40);
    c0 = fetch_count;
    cyc(1, 1, 1, 1, 32'h30);
    chk("rdj_addr", imem_addr, 32'h30);
    chk("rdj_valid", {31'd0, out_valid}, 0);
    chk("rdj_count", fetch_count, c0);
    cyc(1, 1, 1, 0, 0);
    chk("rdj_target", out_pc, 32'h30);
    cyc(1, 0, 1, 0, 0);
    chk("fen_off_valid", {31'd0, out_valid}, 0);
    chk("fen_off_addr", imem_addr, 32'h34);
    cyc(1, 0, 1, 0, 0);
    chk("idle_hold", imem_addr, 32'h34);
    cyc(1, 1, 1, 0, 0);
    chk("rerun_nofetch", {31'd0, out_valid}, 0);
    cyc(1, 1, 1, 0, 0);
    chk("rerun_pc", out_pc, 32'h34);
    cyc(1, 1, 1, 1, 32'hFFFF_FFFE);
    chk("wrap_align", imem_addr, 32'hFFFF_FFFC);
    cyc(1, 1, 1, 0, 0);
    chk("wrap_outpc", out_pc, 32'hFFFF_FFFC);
    chk("wrap_pc4", out_pc4, 0);
    chk("wrap_addr", imem_addr, 0);
    cyc(0, 1, 1, 0, 0);
    chk("mrst_valid", {31'd0, out_valid}, 0);
    chk("mrst_count", fetch_count, 0);
    chk("mrst_inst", out_inst, 0);
    chk("mrst_addr", imem_addr, 0);
    for (int i = 32; i < 63; i += 5) rom[i] = {6'b010010, 26'($urandom)};
    for (int i = 0; i < 600; i++)
      cyc($urandom_range(0, 99) != 0, $urandom_range(0, 9) != 0, $urandom_range(0, 3) != 0,
          $urandom_range(0, 15) == 0,
          ($urandom_range(0, 7) == 0) ? $urandom : {24'd0, 8'($urandom)});
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
